// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 7-segment scanner with frame-aligned double buffering
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    input  logic                enable,
    output logic [3:0]          BCD,
    output logic [DIGITS-1:0]   an,
    output logic [IW-1:0]       digit_idx,
    output logic                busy,
    output logic                frame_done
);

    logic [PW-1:0]         presc, presc_nxt;
    logic [IW-1:0]         idx_nxt;
    logic [4*DIGITS-1:0]   disp, disp_nxt, pend, pend_nxt;
    logic                  busy_nxt, frame_nxt, active, active_nxt;
    logic [3:0]            bcd_nxt;
    logic [DIGITS-1:0]     an_nxt;
    logic                  wrap, last, boundary, lit;

    assign wrap     = (presc == PW'(PRESCALE - 1));
    assign last     = (digit_idx == IW'(DIGITS - 1));
    assign boundary = enable && active && wrap && last;

    always_comb begin
        presc_nxt  = presc;
        idx_nxt    = digit_idx;
        disp_nxt   = disp;
        pend_nxt   = pend;
        busy_nxt   = busy;
        frame_nxt  = 1'b0;
        active_nxt = enable;
        if (!enable) begin
            presc_nxt = '0;
            idx_nxt   = '0;
            busy_nxt  = 1'b0;
            if (load)
                disp_nxt = value;
            else if (busy)
                disp_nxt = pend;
        end else if (!active) begin
            // First enabled edge restarts slot 0 with a fresh prescaler so it gets a full slot.
            presc_nxt = '0;
            idx_nxt   = '0;
            if (load) begin
                pend_nxt = value;
                busy_nxt = 1'b1;
            end
        end else begin
            if (wrap) begin
                presc_nxt = '0;
                idx_nxt   = last ? '0 : digit_idx + IW'(1);
            end else begin
                presc_nxt = presc + PW'(1);
            end
            if (boundary) begin
                frame_nxt = 1'b1;
                busy_nxt  = 1'b0;
                if (load)
                    disp_nxt = value;
                else if (busy)
                    disp_nxt = pend;
            end else if (load) begin
                pend_nxt = value;
                busy_nxt = 1'b1;
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A slot is dark when it and every more significant nibble are zero; digit 0 never is.
    always_comb begin
        lit = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx_nxt) && disp_nxt[4*j +: 4] != 4'd0)
                lit = 1'b1;
        end
        if (idx_nxt == '0)
            lit = 1'b1;
    end
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        bcd_nxt = disp_nxt[4*int'(idx_nxt) +: 4];
        an_nxt  = '1;
        if (enable && lit)
            an_nxt = ~(DIGITS'(1) << idx_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            digit_idx  <= '0;
            disp       <= '0;
            pend       <= '0;
            busy       <= 1'b0;
            BCD        <= 4'd0;
            an         <= '1;
            frame_done <= 1'b0;
            active     <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            digit_idx  <= idx_nxt;
            disp       <= disp_nxt;
            pend       <= pend_nxt;
            busy       <= busy_nxt;
            BCD        <= bcd_nxt;
            an         <= an_nxt;
            frame_done <= frame_nxt;
            active     <= active_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver (DIGITS=4, PRESCALE=4)
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic [3:0]  BCD;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        busy;
    logic        frame_done;

    int n_cmp;
    int n_fail;

    seg_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .enable     (enable),
        .BCD        (BCD),
        .an         (an),
        .digit_idx  (digit_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {an, BCD, digit_idx, busy, frame_done} for a lit slot.
    function automatic logic [11:0] exp_vec(input int idx, input logic [15:0] d,
                                            input logic b, input logic fd);
        logic [3:0] a;
        a = ~(4'b0001 << idx);
        return {a, d[4*idx +: 4], 2'(idx), b, fd};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic restart(input logic [15:0] v);
        enable = 1'b0;
        load   = 1'b1;
        value  = v;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        value  = 16'h0;
        repeat (2) tick();
        n_cmp++;
        if ({an, BCD, digit_idx, busy, frame_done} !== {4'b1111, 4'd0, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", {an, BCD, digit_idx, busy, frame_done},
                     {4'b1111, 4'd0, 2'd0, 1'b0, 1'b0});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scan();
        logic [11:0] e;
        enable = 1'b0;
        load   = 1'b1;
        value  = 16'h1234;
        tick();
        n_cmp++;
        if ({an, BCD, digit_idx, busy, frame_done} !== {4'b1111, 4'd4, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL scan_disabled got %h want %h", {an, BCD, digit_idx, busy, frame_done},
                     {4'b1111, 4'd4, 2'd0, 1'b0, 1'b0});
        end
        load   = 1'b0;
        enable = 1'b1;
        tick();
        for (int t = 0; t < 18; t++) begin
            e = exp_vec((t / 4) % 4, 16'h1234, 1'b0, t == 16);
            n_cmp++;
            if ({an, BCD, digit_idx, busy, frame_done} !== e) begin
                n_fail++;
                $display("FAIL scan t=%0d got %h want %h", t, {an, BCD, digit_idx, busy, frame_done}, e);
            end
            tick();
        end
    endtask

    task automatic test_pending_commit();
        logic [11:0] e;
        restart(16'h1234);
        for (int t = 0; t < 20; t++) begin
            e = exp_vec((t / 4) % 4, (t < 16) ? 16'h1234 : 16'h5678, t >= 6 && t < 16, t == 16);
            n_cmp++;
            if ({an, BCD, digit_idx, busy, frame_done} !== e) begin
                n_fail++;
                $display("FAIL pending_commit t=%0d got %h want %h", t, {an, BCD, digit_idx, busy, frame_done}, e);
            end
            load  = (t == 5);
            value = 16'h5678;
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_last_write_wins();
        logic [11:0] e;
        restart(16'h1234);
        for (int t = 0; t < 20; t++) begin
            e = exp_vec((t / 4) % 4, (t < 16) ? 16'h1234 : 16'h2222, t >= 2 && t < 16, t == 16);
            n_cmp++;
            if ({an, BCD, digit_idx, busy, frame_done} !== e) begin
                n_fail++;
                $display("FAIL last_write_wins t=%0d got %h want %h", t, {an, BCD, digit_idx, busy, frame_done}, e);
            end
            load  = (t == 1) || (t == 9);
            value = (t == 1) ? 16'h1111 : 16'h2222;
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_boundary_load();
        logic [11:0] e;
        restart(16'h1234);
        for (int t = 0; t < 20; t++) begin
            e = exp_vec((t / 4) % 4, (t < 16) ? 16'h1234 : 16'h9999, t >= 7 && t < 16, t == 16);
            n_cmp++;
            if ({an, BCD, digit_idx, busy, frame_done} !== e) begin
                n_fail++;
                $display("FAIL boundary_load t=%0d got %h want %h", t, {an, BCD, digit_idx, busy, frame_done}, e);
            end
            load  = (t == 6) || (t == 15);
            value = (t == 6) ? 16'h5555 : 16'h9999;
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_disable_commit();
        restart(16'h1234);
        tick();
        load  = 1'b1;
        value = 16'h4321;
        tick();
        load = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_busy got %b want 1", busy);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if ({an, BCD, digit_idx, busy, frame_done} !== {4'b1111, 4'd1, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL disable_commit got %h want %h", {an, BCD, digit_idx, busy, frame_done},
                     {4'b1111, 4'd1, 2'd0, 1'b0, 1'b0});
        end
        load  = 1'b1;
        value = 16'h8765;
        tick();
        load = 1'b0;
        n_cmp++;
        if ({an, BCD, digit_idx, busy, frame_done} !== {4'b1111, 4'd5, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL disabled_load got %h want %h", {an, BCD, digit_idx, busy, frame_done},
                     {4'b1111, 4'd5, 2'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        restart(16'h1234);
        repeat (5) tick();
        load  = 1'b1;
        value = 16'h5678;
        tick();
        load = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({an, busy} !== {4'b1011, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset got %h want %h", {an, busy}, {4'b1011, 1'b1});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({an, BCD, digit_idx, busy, frame_done} !== {4'b1111, 4'd0, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset got %h want %h", {an, BCD, digit_idx, busy, frame_done},
                     {4'b1111, 4'd0, 2'd0, 1'b0, 1'b0});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef SEG_LEADING_ZERO_BLANK_EN
    task automatic test_blank();
        logic [11:0] e;
        logic [3:0]  a;
        restart(16'h0050);
        for (int t = 0; t < 17; t++) begin
            a = ((t / 4) % 4 == 0) ? 4'b1110 : ((t / 4) % 4 == 1) ? 4'b1101 : 4'b1111;
            e = {a, ((t / 4) % 4 == 1) ? 4'd5 : 4'd0, 2'((t / 4) % 4), 1'b0, t == 16};
            n_cmp++;
            if ({an, BCD, digit_idx, busy, frame_done} !== e) begin
                n_fail++;
                $display("FAIL blank_0050 t=%0d got %h want %h", t, {an, BCD, digit_idx, busy, frame_done}, e);
            end
            tick();
        end
        restart(16'h0000);
        for (int t = 0; t < 17; t++) begin
            a = ((t / 4) % 4 == 0) ? 4'b1110 : 4'b1111;
            e = {a, 4'd0, 2'((t / 4) % 4), 1'b0, t == 16};
            n_cmp++;
            if ({an, BCD, digit_idx, busy, frame_done} !== e) begin
                n_fail++;
                $display("FAIL blank_0000 t=%0d got %h want %h", t, {an, BCD, digit_idx, busy, frame_done}, e);
            end
            tick();
        end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_scan();
        test_pending_commit();
        test_last_write_wins();
        test_boundary_load();
        test_disable_commit();
        test_async_reset();
`ifdef SEG_LEADING_ZERO_BLANK_EN
        test_blank();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
